// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit that sits between the
// execute stage and a grant/rvalid data-memory port. It lane-aligns store data,
// generates byte enables, and shifts/extends load data for write-back.
// Optional feature: define MISALIGN_CHECK_EN to trap misaligned half/word
// accesses. A trapped access raises a one-cycle misalign pulse and never
// reaches memory. When the macro is undefined, every access goes to memory,
// and lanes past byte 3 are dropped.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        ex_ready,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        mis_acc;
  logic [1:0]  off;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        is_load;
  logic [3:0]  be_enc;
  logic [31:0] wdata_enc;
  logic [31:0] s;
  logic [31:0] ld_ext;

  // A load or a store is accepted only from IDLE. A request with neither
  // flag set is dropped.
  assign off      = ex_addr[1:0];
  assign accept   = ex_valid && ex_ready && (ex_load || ex_store);
  assign ex_ready = (state == IDLE);
  // The request and write-back strobes decode straight from the state. An
  // async reset therefore drops them in the same instant.
  assign dm_req   = (state == REQ);
  assign wb_valid = (state == WB);

`ifdef MISALIGN_CHECK_EN
  // Byte accesses are always aligned. Halfwords need off[0]=0. Words and the
  // remaining codes need off=0.
  always_comb begin
    mis_acc = 1'b0;
    case (ex_funct3)
      3'b000, 3'b100: mis_acc = 1'b0;
      3'b001, 3'b101: mis_acc = off[0];
      default:        mis_acc = (off != 2'b00);
    endcase
  end

  // The trap pulse appears in the cycle after the offending accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= accept && mis_acc;
  end
`else
  assign mis_acc  = 1'b0;
  assign misalign = 1'b0;
`endif

  // Store lane alignment. The left shift keeps 4 bits, so a halfword at
  // off=3 keeps only lane 3. Loads always read the whole word.
  always_comb begin
    be_enc    = 4'b1111;
    wdata_enc = ex_wdata;
    if (ex_load) begin
      wdata_enc = 32'h0;
    end else begin
      case (ex_funct3)
        3'b000: begin
          be_enc    = 4'b0001 << off;
          wdata_enc = {4{ex_wdata[7:0]}};
        end
        3'b001: begin
          be_enc    = 4'b0011 << off;
          wdata_enc = {2{ex_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Move the addressed byte lane down to bit 0, then extend by access type.
  assign s = dm_rdata >> {off_q, 3'b000};
  always_comb begin
    ld_ext = s;
    case (f3_q)
      3'b000:  ld_ext = {{24{s[7]}}, s[7:0]};
      3'b001:  ld_ext = {{16{s[15]}}, s[15:0]};
      3'b100:  ld_ext = {24'h0, s[7:0]};
      3'b101:  ld_ext = {16'h0, s[15:0]};
      default: ld_ext = s;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. A trapped misaligned access stays in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !mis_acc) state_nxt = REQ;
      REQ:     if (dm_gnt) state_nxt = is_load ? RESP : IDLE;
      RESP:    if (dm_rvalid) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request at accept. The memory-side fields then stay frozen
  // through REQ. Load data is captured only in RESP, so a stray rvalid is
  // ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_load  <= 1'b0;
      f3_q     <= 3'b0;
      off_q    <= 2'b0;
      rd_q     <= 5'b0;
      dm_we    <= 1'b0;
      dm_be    <= 4'b0;
      dm_addr  <= 32'h0;
      dm_wdata <= 32'h0;
      wb_rd    <= 5'b0;
      wb_data  <= 32'h0;
    end else begin
      if (accept && !mis_acc) begin
        is_load  <= ex_load;
        f3_q     <= ex_funct3;
        off_q    <= off;
        rd_q     <= ex_rd;
        dm_we    <= !ex_load;
        dm_be    <= be_enc;
        dm_addr  <= {ex_addr[31:2], 2'b00};
        dm_wdata <= wdata_enc;
      end
      if (state == RESP && dm_rvalid) begin
        wb_rd   <= rd_q;
        wb_data <= ld_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with hand-computed results for
// load_store_unit. Inputs change 1 ns after a rising edge, and outputs are
// sampled on the falling edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'b0;
  logic [31:0] ex_addr = 32'h0, ex_wdata = 32'h0;
  logic [4:0]  ex_rd = 5'h0;
  logic        ex_ready;
  logic        dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt = 1'b0, dm_rvalid = 1'b0;
  logic [31:0] dm_rdata = 32'h0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int n_pass = 0;
  int n_tot  = 0;
  int wb_cnt = 0;
  int req_cnt = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .ex_ready(ex_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Count the cycles in which wb_valid or dm_req is high.
  always @(negedge clk) begin
    if (wb_valid) wb_cnt++;
    if (dm_req)   req_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_load = ld; ex_store = st;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    tick();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
  endtask

  // Store with an immediate grant: the request is live in T1, and the unit is
  // ready again in T2 with no write-back.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] e_addr,
                          input logic [3:0] e_be, input logic [31:0] e_wd);
    int w0;
    w0 = wb_cnt;
    send(1'b0, 1'b1, f3, a, wd, 5'd0);
    dm_gnt = 1'b1;
    mid();
    chk({tag, "_req"},   dm_req, 1);
    chk({tag, "_we"},    dm_we, 1);
    chk({tag, "_addr"},  dm_addr, e_addr);
    chk({tag, "_be"},    dm_be, e_be);
    chk({tag, "_wdata"}, dm_wdata, e_wd);
    chk({tag, "_mis"},   misalign, 0);
    tick();
    dm_gnt = 1'b0;
    mid();
    chk({tag, "_ready"}, ex_ready, 1);
    chk({tag, "_req0"},  dm_req, 0);
    tick();
    chk({tag, "_nowb"},  wb_cnt - w0, 0);
  endtask

  // Load with the grant delayed gd cycles and rvalid delayed rd_dly cycles.
  // While the request waits for its grant, a stray rvalid carrying junk data
  // is driven; it must have no effect.
  task automatic do_load(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [4:0] rd, input logic [31:0] rdata,
                         input int gd, input int rd_dly, input logic [31:0] e_addr,
                         input logic [31:0] e_data);
    int w0, r0;
    w0 = wb_cnt; r0 = req_cnt;
    send(1'b1, st, f3, a, 32'h0, rd);
    for (int i = 0; i < gd; i++) begin
      dm_rvalid = 1'b1; dm_rdata = 32'hBAD0BAD0;
      mid();
      chk({tag, "_wreq"},   dm_req, 1);
      chk({tag, "_wrdy"},   ex_ready, 0);
      chk({tag, "_waddr"},  dm_addr, e_addr);
      chk({tag, "_wbe"},    dm_be, 4'b1111);
      chk({tag, "_wwe"},    dm_we, 0);
      tick();
    end
    dm_rvalid = 1'b0; dm_gnt = 1'b1;
    mid();
    chk({tag, "_req"},  dm_req, 1);
    chk({tag, "_addr"}, dm_addr, e_addr);
    chk({tag, "_be"},   dm_be, 4'b1111);
    chk({tag, "_we"},   dm_we, 0);
    tick();
    dm_gnt = 1'b0;
    for (int i = 0; i < rd_dly; i++) begin
      mid();
      chk({tag, "_rreq"}, dm_req, 0);
      chk({tag, "_rrdy"}, ex_ready, 0);
      chk({tag, "_rwb"},  wb_valid, 0);
      tick();
    end
    dm_rvalid = 1'b1; dm_rdata = rdata;
    mid();
    chk({tag, "_rvwb"}, wb_valid, 0);
    tick();
    dm_rvalid = 1'b0; dm_rdata = 32'h0;
    mid();
    chk({tag, "_wbv"},   wb_valid, 1);
    chk({tag, "_wbrd"},  wb_rd, rd);
    chk({tag, "_wbd"},   wb_data, e_data);
    chk({tag, "_wbrdy"}, ex_ready, 0);
    tick();
    mid();
    chk({tag, "_wbv0"},  wb_valid, 0);
    chk({tag, "_hold"},  wb_data, e_data);
    chk({tag, "_rdy"},   ex_ready, 1);
    tick();
    chk({tag, "_wbcnt"},  wb_cnt - w0, 1);
    chk({tag, "_reqcnt"}, req_cnt - r0, gd + 1);
  endtask

  initial begin
    int w0, r0;
    // Reset values while rst is held.
    #12;
    chk("rst_ready", ex_ready, 1);
    chk("rst_req",   dm_req, 0);
    chk("rst_we",    dm_we, 0);
    chk("rst_be",    dm_be, 0);
    chk("rst_addr",  dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    chk("rst_wbv",   wb_valid, 0);
    chk("rst_wbrd",  wb_rd, 0);
    chk("rst_wbd",   wb_data, 0);
    chk("rst_mis",   misalign, 0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Stores.
    do_store("sb",  3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
    do_store("sh",  3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD);
    do_store("sw",  3'b010, 32'h0000_0010, 32'h1122_3344, 32'h0000_0010, 4'b1111, 32'h1122_3344);

    // Loads at minimum latency.
    do_load("lb",  1'b0, 3'b000, 32'h0000_0102, 5'd5, 32'h12F0_3456, 0, 0, 32'h0000_0100, 32'hFFFF_FFF0);
    do_load("lbu", 1'b0, 3'b100, 32'h0000_0102, 5'd5, 32'h12F0_3456, 0, 0, 32'h0000_0100, 32'h0000_00F0);
    do_load("lh",  1'b0, 3'b001, 32'h0000_0202, 5'd9, 32'h8001_ABCD, 0, 0, 32'h0000_0200, 32'hFFFF_8001);
    do_load("lhu", 1'b0, 3'b101, 32'h0000_0202, 5'd9, 32'h8001_ABCD, 0, 0, 32'h0000_0200, 32'h0000_8001);
    do_load("lhp", 1'b0, 3'b001, 32'h0000_0040, 5'd2, 32'hFFFF_7FFF, 0, 0, 32'h0000_0040, 32'h0000_7FFF);
    do_load("lb0", 1'b0, 3'b000, 32'h0000_0003, 5'd0, 32'h8000_0000, 0, 0, 32'h0000_0000, 32'hFFFF_FF80);
    // Load with a slow grant and slow read data.
    do_load("lwd", 1'b0, 3'b010, 32'h0000_0300, 5'd7, 32'hDEAD_BEEF, 3, 2, 32'h0000_0300, 32'hDEAD_BEEF);
    // Load and store both set: the access is a load.
    do_load("both", 1'b1, 3'b010, 32'h0000_0020, 5'd3, 32'hCAFE_F00D, 1, 1, 32'h0000_0020, 32'hCAFE_F00D);

    // ex_valid with neither load nor store set is ignored.
    ex_valid = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h0000_0500;
    tick();
    ex_valid = 1'b0;
    mid();
    chk("nop_ready", ex_ready, 1);
    chk("nop_req",   dm_req, 0);
    tick();

    // Reset while waiting in RESP; the rvalid that follows the reset is ignored.
    w0 = wb_cnt;
    send(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd7);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    mid();
    chk("rr_resp", ex_ready, 0);
    rst = 1'b1;
    #1;
    chk("rr_req",   dm_req, 0);
    chk("rr_wbv",   wb_valid, 0);
    chk("rr_ready", ex_ready, 1);
    chk("rr_addr",  dm_addr, 0);
    chk("rr_wbd",   wb_data, 0);
    tick();
    rst = 1'b0;
    dm_rvalid = 1'b1; dm_rdata = 32'h1357_9BDF;
    tick();
    dm_rvalid = 1'b0;
    tick(); tick();
    chk("rr_nowb",  wb_cnt - w0, 0);
    chk("rr_ready2", ex_ready, 1);
    chk("rr_wbd2",  wb_data, 0);

`ifdef MISALIGN_CHECK_EN
    // A misaligned word load is trapped: misalign pulses once, and no request is made.
    r0 = req_cnt; w0 = wb_cnt;
    send(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd1);
    mid();
    chk("mis_pulse", misalign, 1);
    chk("mis_req",   dm_req, 0);
    chk("mis_ready", ex_ready, 1);
    tick();
    mid();
    chk("mis_pulse0", misalign, 0);
    tick();
    chk("mis_reqcnt", req_cnt - r0, 0);
    chk("mis_nowb",   wb_cnt - w0, 0);
`else
    // Without the trap, a halfword at offset 3 keeps only the top lane.
    r0 = req_cnt;
    do_store("sh3", 3'b001, 32'h0000_0103, 32'h0000_BEEF, 32'h0000_0100, 4'b1000, 32'hBEEF_BEEF);
    chk("sh3_reqcnt", req_cnt - r0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  // Watchdog so the bench ends even if the run stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have clk, input, 1, rising-edge clock.
REQ-002 The block SHALL have rst, input, 1, reset; asynchronous, active-high.
REQ-003 The block SHALL have these request inputs from the pipeline:
- ex_valid, 1: request valid.
- ex_load, 1: load request.
- ex_store, 1: store request.
- ex_funct3, 3: access size/sign.
- ex_addr, 32: byte address.
- ex_wdata, 32: store source data.
- ex_rd, 5: load destination register.
REQ-004 The block SHALL have ex_ready, output, 1, which is high when a new request can be accepted.
REQ-005 The block SHALL have these data-memory outputs:
- dm_req, 1: memory request.
- dm_we, 1: write.
- dm_be, 4: byte enables.
- dm_addr, 32: word address, bits [1:0] forced to 0.
- dm_wdata, 32: lane-aligned write data.
REQ-006 The block SHALL have these data-memory inputs:
- dm_gnt, 1: request accepted.
- dm_rvalid, 1: read data valid.
- dm_rdata, 32: read word.
REQ-007 The block SHALL have these write-back outputs:
- wb_valid, 1: one-cycle result pulse.
- wb_rd, 5: destination register.
- wb_data, 32: extended load result.
REQ-008 The block SHALL have misalign, output, 1, a one-cycle misaligned-access pulse.

Function
REQ-009 The FSM SHALL have four states: IDLE, REQ, RESP and WB; ex_ready SHALL equal (state==IDLE).
REQ-010 A request SHALL be accepted when ex_valid && ex_ready && (ex_load || ex_store); accepted fields SHALL be registered, and the FSM SHALL go to REQ.
REQ-011 ex_valid with neither ex_load nor ex_store SHALL be ignored; if both are set, the request SHALL be treated as a load.
REQ-012 In REQ, dm_req SHALL be 1, and dm_addr/dm_we/dm_be/dm_wdata SHALL be held stable until the cycle in which dm_gnt=1.
REQ-013 On grant, a store SHALL go to IDLE with no wb_valid; a load SHALL go to RESP.
REQ-014 In RESP, dm_rvalid=1 SHALL capture the extended data and go to WB.
REQ-015 In WB, wb_valid SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-016 dm_rvalid outside RESP SHALL be ignored.
REQ-017 Minimum load latency SHALL be: accept T0, dm_req T1 (gnt T1), rvalid T2, wb_valid T3; minimum store latency SHALL be accept T0, grant T1, ex_ready T2.
REQ-018 Let off = addr[1:0]. Store encoding SHALL be:
- SB (000): be = 4'b0001<<off; wdata = byte replicated x4.
- SH (001): be = 4'b0011<<off, truncated to 4 bits; wdata = halfword replicated x2.
- SW (010) and other codes: be = 4'b1111; wdata = ex_wdata.
REQ-019 dm_we SHALL be 1 for stores and 0 for loads; loads SHALL drive dm_be=4'b1111.
REQ-020 Load data SHALL be computed as s = dm_rdata >> (8*off), then extended as follows:
- LB (000): sign-extend s[7:0].
- LH (001): sign-extend s[15:0].
- LBU (100): zero-extend s[7:0].
- LHU (101): zero-extend s[15:0].
- LW (010) and other codes: s.
REQ-021 A load with rd=0 SHALL still access memory and pulse wb_valid with wb_rd=0.
REQ-022 wb_rd and wb_data SHALL hold their last values outside wb_valid.

Reset
REQ-023 While rst=1, the block SHALL hold: state=IDLE, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0, wb_valid=0, wb_rd=0, wb_data=0, misalign=0.
REQ-024 rst during REQ, RESP or WB SHALL immediately drop dm_req and wb_valid and abandon the transaction; a pending dm_rvalid after reset SHALL be ignored.

Configuration
REQ-025 With MISALIGN_CHECK_EN defined, the following SHALL be misaligned: LH/LHU/SH with off[0]=1, and LW/SW (or their default codes) with off!=0.
REQ-026 A misaligned access SHALL issue no dm_req and no wb_valid, SHALL pulse misalign one cycle after accept, and SHALL return to IDLE.
REQ-027 Without MISALIGN_CHECK_EN:
- misalign SHALL be tied 0.
- All accesses SHALL proceed per REQ-018/REQ-020, with lanes beyond byte 3 dropped (e.g. SH at off=3 gives be=4'b1000).

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- SB, addr 0x103, wdata 0x000000A5 -> dm_addr 0x100, be 4'b1000, dm_wdata 0xA5A5A5A5, no wb_valid.
- LB, addr 0x102, rdata 0x12F03456, rd 5 -> wb_data 0xFFFFFFF0, wb_rd 5; LBU at the same address -> 0x000000F0.
- LH, addr 0x202, rdata 0x8001ABCD -> wb_data 0xFFFF8001; LHU -> 0x00008001.
- LW with dm_gnt delayed 3 cycles and rvalid 2 more -> dm_req held 4 cycles with stable outputs, single wb_valid, ex_ready low throughout.
- rst asserted in RESP, then dm_rvalid -> dm_req=0, wb_valid never asserts, ex_ready=1 after reset.
- MISALIGN_CHECK_EN defined, LW at 0x101 -> misalign pulse, no dm_req; macro undefined, SH at 0x103 -> be 4'b1000.
